// File: rtl/branch_hazard_unit_pkg.sv
// Shared constants, stage-record type and match helper for the branch hazard unit.
// The branch operand mux imports the same BR_HAZ_* select codes.
package br_haz_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int BR_HAZ_W   = 3;

    localparam logic [BR_HAZ_W-1:0] BR_HAZ_NONE   = 3'd0;
    localparam logic [BR_HAZ_W-1:0] BR_HAZ_ALU_A  = 3'd1;
    localparam logic [BR_HAZ_W-1:0] BR_HAZ_ALU_B  = 3'd2;
    localparam logic [BR_HAZ_W-1:0] BR_HAZ_DMEM_A = 3'd3;
    localparam logic [BR_HAZ_W-1:0] BR_HAZ_DMEM_B = 3'd4;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

    typedef enum logic [1:0] {
        NEED_NONE,
        NEED_ALU,
        NEED_DMEM,
        NEED_LOAD
    } op_need_t;

    // x0 is hardwired, so a record writing x0 never produces a match.
    function automatic logic rec_match(input stage_rec_t rec, input logic [REG_ADDR_W-1:0] rs);
        return rec.valid & rec.we & (rec.rd != '0) & (rec.rd == rs);
    endfunction

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Decode-side bundle between the decoder (master) and the branch hazard unit (slave).
interface branch_hazard_unit_if;
    import br_haz_pkg::*;

    logic                  id_valid;
    logic                  id_br_use;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_we;
    logic                  id_is_load;
    logic                  flush;
    logic [BR_HAZ_W-1:0]   br_haz;
    logic                  stall;

    modport master (
        output id_valid, id_br_use, id_rs1, id_rs2, id_rd, id_reg_we, id_is_load, flush,
        input  br_haz, stall
    );

    modport slave (
        input  id_valid, id_br_use, id_rs1, id_rs2, id_rd, id_reg_we, id_is_load, flush,
        output br_haz, stall
    );

endinterface

// File: rtl/branch_hazard_unit_br_stage_track.sv
// EX/MEM destination-record pipeline: MEM always takes EX, EX takes the ID record or a bubble.
module br_stage_track
    import br_haz_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  stage_rec_t id_rec,
    output stage_rec_t ex_rec,
    output stage_rec_t mem_rec
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rec  <= STAGE_BUBBLE;
            mem_rec <= STAGE_BUBBLE;
        end else begin
            mem_rec <= ex_rec;
            ex_rec  <= load_en ? id_rec : STAGE_BUBBLE;
        end
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch forwarding select and load/dual-operand stall generation for the decode stage.
// Optional stall-cycle counter enabled by defining BR_HAZ_PERF_EN.
module branch_hazard_unit
    import br_haz_pkg::*;
#(
`ifdef BR_HAZ_PERF_EN
    parameter int PERF_W = 32
`endif
)(
    input  logic                 clk,
    input  logic                 rst_n,
    branch_hazard_unit_if.slave  bus
`ifdef BR_HAZ_PERF_EN
    ,
    output logic [PERF_W-1:0]    stall_cycles
`endif
);

    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    stage_rec_t id_rec;
    logic       load_en;
    op_need_t   need_a;
    op_need_t   need_b;

    function automatic op_need_t classify(input stage_rec_t ex, input stage_rec_t mem,
                                          input logic [REG_ADDR_W-1:0] rs);
        if (rec_match(ex, rs))
            return ex.is_load ? NEED_LOAD : NEED_ALU;
        else if (rec_match(mem, rs))
            return NEED_DMEM;
        else
            return NEED_NONE;
    endfunction

    assign id_rec.valid   = bus.id_valid;
    assign id_rec.we      = bus.id_reg_we;
    assign id_rec.rd      = bus.id_rd;
    assign id_rec.is_load = bus.id_is_load;

    // A flushed or stalled instruction must not reach EX; either way a bubble goes in.
    assign load_en = bus.id_valid & ~bus.stall & ~bus.flush;

    br_stage_track u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (load_en),
        .id_rec  (id_rec),
        .ex_rec  (ex_rec),
        .mem_rec (mem_rec)
    );

    assign need_a = classify(ex_rec, mem_rec, bus.id_rs1);
    assign need_b = classify(ex_rec, mem_rec, bus.id_rs2);

    // The mux can forward only one operand, so two live hazards also stall.
    always_comb begin
        bus.br_haz = BR_HAZ_NONE;
        bus.stall  = 1'b0;
        if (bus.id_valid && bus.id_br_use) begin
            if (need_a == NEED_LOAD || need_b == NEED_LOAD) begin
                bus.stall = 1'b1;
            end else if (need_a != NEED_NONE && need_b != NEED_NONE) begin
                bus.stall = 1'b1;
            end else if (need_a == NEED_ALU) begin
                bus.br_haz = BR_HAZ_ALU_A;
            end else if (need_a == NEED_DMEM) begin
                bus.br_haz = BR_HAZ_DMEM_A;
            end else if (need_b == NEED_ALU) begin
                bus.br_haz = BR_HAZ_ALU_B;
            end else if (need_b == NEED_DMEM) begin
                bus.br_haz = BR_HAZ_DMEM_B;
            end
        end
    end

`ifdef BR_HAZ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (bus.stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule
